t_demux_13x1: RTL and testbench



---
 rtl/t_demux_13x1_if.sv | 23 ++
 rtl/t_demux_13x1.sv | 116 +++++++++++
 tb/tb_t_demux_13x1.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/t_demux_13x1_if.sv
// Write port and slot readout of the 13-slot byte demultiplexer.
// The bench uses master. The demultiplexer uses slave.
interface t_demux_13x1_if;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             sof;
  logic             clear;
  logic             wr_ready;
  logic [12:0][7:0] x;
  logic [3:0]       idx;
  logic             frame_done;
  logic             err;

  modport master (
    output wr_valid, wr_data, sof, clear,
    input  wr_ready, x, idx, frame_done, err
  );

  modport slave (
    input  wr_valid, wr_data, sof, clear,
    output wr_ready, x, idx, frame_done, err
  );
endinterface

// File: rtl/t_demux_13x1.sv
// Scatters a 13-byte frame, marked by sof, into 13 registered slots x0..x12.
// err pulses on a stray byte or a frame restart. frame_done pulses when a frame completes.
module t_demux_13x1 #(
  parameter logic [7:0] RST_BYTE = 8'h00
) (
  input  logic           clk,
  input  logic           reset,
  t_demux_13x1_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       wr_en;
  logic [3:0] wr_sel;
  logic       xfer;
  logic [7:0] slot_q [13];

  assign bus.wr_ready   = (state_q != DONE);
  assign xfer           = bus.wr_valid && bus.wr_ready;
  assign bus.idx        = idx_q;
  assign bus.err        = err_q;
  assign bus.frame_done = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = idx_q;
    if (bus.clear) begin
      // Clear wins over a concurrent transfer. That byte is dropped silently.
      state_d = IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (bus.sof) begin
              wr_en   = 1'b1;
              wr_sel  = 4'd0;
              idx_d   = 4'd1;
              state_d = FILL;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        FILL: begin
          if (xfer) begin
            wr_en = 1'b1;
            if (bus.sof) begin
              wr_sel = 4'd0;
              idx_d  = 4'd1;
              err_d  = 1'b1;
            end else if (idx_q == 4'd12) begin
              idx_d   = 4'd0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 13; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          slot_q[gi] <= RST_BYTE;
        end else if (bus.clear) begin
          slot_q[gi] <= RST_BYTE;
        end else if (wr_en && (wr_sel == 4'(gi))) begin
          slot_q[gi] <= bus.wr_data;
        end
      end
    end
  endgenerate

  always_comb begin
    bus.x = '0;
    for (int i = 0; i < 13; i++) begin
      bus.x[i] = slot_q[i];
    end
  end

endmodule

// File: tb/tb_t_demux_13x1.sv
// Directed checks for t_demux_13x1: per-cycle vector table plus hand sequences for reset and clear.
module tb_t_demux_13x1;

  typedef struct {
    logic       v;
    logic       s;
    logic       c;
    logic [7:0] d;
    logic [3:0] e_idx;
    logic       e_rdy;
    logic       e_err;
    logic       e_done;
  } vec_t;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  logic [7:0] ex [13];
  vec_t vecs [$];

  t_demux_13x1_if bus ();

  t_demux_13x1 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_slots(input string tag);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("%s x%0d", tag, i), int'(bus.x[i]), int'(ex[i]));
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    bus.wr_valid = t.v;
    bus.sof      = t.s;
    bus.clear    = t.c;
    bus.wr_data  = t.d;
    @(posedge clk);
    #1;
    $display("%s: v=%0b sof=%0b clr=%0b d=%02h -> idx=%0d rdy=%0b err=%0b done=%0b",
             tag, t.v, t.s, t.c, t.d, bus.idx, bus.wr_ready, bus.err, bus.frame_done);
    chk({tag, " idx"},  int'(bus.idx),        int'(t.e_idx));
    chk({tag, " rdy"},  int'(bus.wr_ready),   int'(t.e_rdy));
    chk({tag, " err"},  int'(bus.err),        int'(t.e_err));
    chk({tag, " done"}, int'(bus.frame_done), int'(t.e_done));
    bus.wr_valid = 1'b0;
    bus.sof      = 1'b0;
    bus.clear    = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic s, input logic c, input logic [7:0] d,
                              input int e_idx, input logic e_rdy, input logic e_err,
                              input logic e_done);
    vec_t t;
    t.v = v; t.s = s; t.c = c; t.d = d;
    t.e_idx = 4'(e_idx); t.e_rdy = e_rdy; t.e_err = e_err; t.e_done = e_done;
    return t;
  endfunction

  // Thirteen back-to-back bytes 10..1C, then one ignored byte during DONE.
  task automatic push_full_frame();
    for (int i = 0; i < 13; i++) begin
      vecs.push_back(mk(1, i == 0, 0, 8'(8'h10 + i), (i + 1) % 13, i != 12, 0, i == 12));
    end
    vecs.push_back(mk(1, 0, 0, 8'hEE, 0, 1, 0, 0));
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[k]) apply(vecs[k], $sformatf("%s[%0d]", tag, k));
    vecs.delete();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    bus.wr_valid = 1'b0;
    bus.sof      = 1'b0;
    bus.clear    = 1'b0;
    bus.wr_data  = 8'h00;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset idx",  int'(bus.idx),        0);
    chk("reset rdy",  int'(bus.wr_ready),   1);
    chk("reset err",  int'(bus.err),        0);
    chk("reset done", int'(bus.frame_done), 0);
    for (int i = 0; i < 13; i++) ex[i] = 8'h00;
    chk_slots("reset");

    // Full frame.
    push_full_frame();
    run_vecs("full");
    for (int i = 0; i < 13; i++) ex[i] = 8'(8'h10 + i);
    chk_slots("full");

    // Clear, then the same bytes with an idle cycle between each.
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 0));
    for (int i = 0; i < 13; i++) begin
      vecs.push_back(mk(1, i == 0, 0, 8'(8'h10 + i), (i + 1) % 13, i != 12, 0, i == 12));
      vecs.push_back(mk(0, 0, 0, 8'h5A, (i + 1) % 13, 1, 0, 0));
    end
    run_vecs("gaps");
    chk_slots("gaps");

    // Stray byte in IDLE.
    vecs.push_back(mk(1, 0, 0, 8'hAA, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0));
    run_vecs("stray");
    chk_slots("stray");

    // Truncated frame: 01..05 then a restart with 99, then one more byte to prove FILL.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, i == 0, 0, 8'(8'h01 + i), i + 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h99, 1, 1, 1, 0));
    run_vecs("trunc");
    ex[0] = 8'h99; ex[1] = 8'h02; ex[2] = 8'h03; ex[3] = 8'h04; ex[4] = 8'h05;
    chk_slots("trunc");
    vecs.push_back(mk(1, 0, 0, 8'h77, 2, 1, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 8'(8'h60 + i), 3 + i, 1, 0, 0));
    run_vecs("fill");
    chk("fill x1", int'(bus.x[1]), 8'h77);
    chk("fill x6", int'(bus.x[6]), 8'h64);

    // Reset mid-frame at idx=7, mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    chk("async reset idx", int'(bus.idx), 0);
    for (int i = 0; i < 13; i++) ex[i] = 8'h00;
    chk_slots("async reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("reset hold done", int'(bus.frame_done), 0);
    end
    reset = 1'b0;
    #1;
    chk("post reset rdy", int'(bus.wr_ready), 1);
    push_full_frame();
    run_vecs("after reset");
    for (int i = 0; i < 13; i++) ex[i] = 8'(8'h10 + i);
    chk_slots("after reset");

    // Clear together with a valid byte at idx=3.
    vecs.push_back(mk(1, 1, 0, 8'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h41, 2, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h42, 3, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 8'h55, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0));
    run_vecs("clear");
    for (int i = 0; i < 13; i++) ex[i] = 8'h00;
    chk_slots("clear");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
